gcd_datapath: RTL and testbench

GCD_DATAPATH -- requirements
Module: gcd_datapath

---
 rtl/gcd_datapath.sv | 130 +++++++++++++
 tb/tb_gcd_datapath.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_datapath.sv
// GCD datapath: holds operands A/B, executes controller subtract commands,
// reports compare flags back, and hands the result off with a valid/ready pair.
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cmd_sub_a,
    input  logic             cmd_sub_b,
    output logic             A_greater_B_flag,
    output logic             done_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH:0]   iter_count,
    output logic             protocol_err
);

    // state | meaning
    // IDLE  | waiting for an operand pair, in_ready=1
    // RUN   | executing controller commands until A == B
    // HOLD  | result presented with out_valid=1 until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [WIDTH:0]   iter_q, iter_d;
    logic             perr_q, perr_d;

    logic             a_gt_b;
    logic             a_eq_b;
    logic [WIDTH:0]   iter_inc;

    assign a_gt_b   = (a_q > b_q);
    assign a_eq_b   = (a_q == b_q);
    assign iter_inc = (&iter_q) ? iter_q : iter_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        iter_d  = iter_q;
        perr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    iter_d = '0;
                    if ((a_in == '0) || (b_in == '0)) begin
                        gcd_d   = a_in | b_in;
                        state_d = HOLD;
                    end else begin
                        a_d     = a_in;
                        b_d     = b_in;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Equality wins over any command issued in the same cycle.
                if (a_eq_b) begin
                    gcd_d   = a_q;
                    state_d = HOLD;
                end else if (cmd_sub_a && cmd_sub_b) begin
                    perr_d = 1'b1;
                end else if (cmd_sub_a) begin
                    if (a_gt_b) begin
                        a_d    = a_q - b_q;
                        iter_d = iter_inc;
                    end else begin
                        perr_d = 1'b1;
                    end
                end else if (cmd_sub_b) begin
                    if (!a_gt_b) begin
                        b_d    = b_q - a_q;
                        iter_d = iter_inc;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready         = (state_q == IDLE);
    assign out_valid        = (state_q == HOLD);
    assign A_greater_B_flag = (state_q == RUN) && a_gt_b;
    assign done_flag        = (state_q == RUN) && a_eq_b;
    assign gcd_out          = gcd_q;
    assign iter_count       = iter_q;
    assign protocol_err     = perr_q;

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath: expected results are queued when an
// operand pair is offered and compared when the result is handed off.
module tb_gcd_datapath;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cmd_sub_a;
    logic             cmd_sub_b;
    logic             A_greater_B_flag;
    logic             done_flag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic [WIDTH:0]   iter_count;
    logic             protocol_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_gcd_q[$];
    logic [31:0] exp_iter_q[$];

    always #5 clk = ~clk;

    gcd_datapath #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a_in             (a_in),
        .b_in             (b_in),
        .cmd_sub_a        (cmd_sub_a),
        .cmd_sub_b        (cmd_sub_b),
        .A_greater_B_flag (A_greater_B_flag),
        .done_flag        (done_flag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .gcd_out          (gcd_out),
        .iter_count       (iter_count),
        .protocol_err     (protocol_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer a pair for one edge and queue the expected result.
    task automatic offer(input int a, input int b, input int exp_g, input int exp_i);
        in_valid = 1'b1;
        a_in     = a[WIDTH-1:0];
        b_in     = b[WIDTH-1:0];
        check_val("in_ready_offer", in_ready, 1);
        exp_gcd_q.push_back(exp_g);
        exp_iter_q.push_back(exp_i);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic sa, input logic sb);
        cmd_sub_a = sa;
        cmd_sub_b = sb;
        step();
        cmd_sub_a = 1'b0;
        cmd_sub_b = 1'b0;
    endtask

    task automatic pop_compare();
        logic [31:0] g, it;
        check_val("sb_nonempty", exp_gcd_q.size() > 0, 1);
        g  = (exp_gcd_q.size() > 0) ? exp_gcd_q.pop_front() : 32'hFFFF_FFFF;
        it = (exp_iter_q.size() > 0) ? exp_iter_q.pop_front() : 32'hFFFF_FFFF;
        check_val("gcd_out", gcd_out, g);
        check_val("iter_count", iter_count, it);
    endtask

    task automatic consume();
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check_val("out_valid_wait", out_valid, 1);
        pop_compare();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("out_valid_after", out_valid, 0);
        check_val("in_ready_after", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cmd_sub_a = 1'b0;
        cmd_sub_b = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_agtb", A_greater_B_flag, 0);
        check_val("rst_done", done_flag, 0);
        check_val("rst_gcd", gcd_out, 0);
        check_val("rst_iter", iter_count, 0);
        check_val("rst_perr", protocol_err, 0);

        // 12,18: sub_b then sub_a -> 6 after two subtractions
        offer(12, 18, 6, 2);
        check_val("t1_agtb0", A_greater_B_flag, 0);
        check_val("t1_done0", done_flag, 0);
        check_val("t1_in_ready", in_ready, 0);
        run_cmd(1'b0, 1'b1);
        check_val("t1_agtb1", A_greater_B_flag, 1);
        check_val("t1_iter1", iter_count, 1);
        run_cmd(1'b1, 1'b0);
        check_val("t1_done", done_flag, 1);
        check_val("t1_perr", protocol_err, 0);
        step();
        check_val("t1_out_valid", out_valid, 1);
        consume();

        // 0,9: straight to HOLD one edge after acceptance
        offer(0, 9, 9, 0);
        check_val("t2_out_valid", out_valid, 1);
        check_val("t2_agtb", A_greater_B_flag, 0);
        check_val("t2_done", done_flag, 0);
        consume();

        offer(0, 0, 0, 0);
        check_val("t2b_out_valid", out_valid, 1);
        consume();

        // 7,7: done in first RUN cycle, result on next edge
        offer(7, 7, 7, 0);
        check_val("t3_done", done_flag, 1);
        check_val("t3_agtb", A_greater_B_flag, 0);
        check_val("t3_out_valid0", out_valid, 0);
        step();
        check_val("t3_out_valid1", out_valid, 1);
        consume();

        // 5,3: illegal sub_b, then legal sequence down to 1
        offer(5, 3, 1, 3);
        run_cmd(1'b0, 1'b1);
        check_val("t4_perr_pulse", protocol_err, 1);
        check_val("t4_iter_hold", iter_count, 0);
        check_val("t4_agtb_hold", A_greater_B_flag, 1);
        check_val("t4_done_hold", done_flag, 0);
        step();
        check_val("t4_perr_clear", protocol_err, 0);
        run_cmd(1'b1, 1'b0);
        check_val("t4_a2_agtb", A_greater_B_flag, 0);
        check_val("t4_a2_iter", iter_count, 1);
        run_cmd(1'b1, 1'b1);
        check_val("t4_both_perr", protocol_err, 1);
        run_cmd(1'b0, 1'b1);
        check_val("t4_b1_agtb", A_greater_B_flag, 1);
        check_val("t4_b1_perr", protocol_err, 0);
        run_cmd(1'b1, 1'b0);
        check_val("t4_done", done_flag, 1);
        consume();

        // Stalled result while a new pair is offered
        offer(12, 12, 12, 0);
        step();
        in_valid = 1'b1;
        a_in     = 8'd3;
        b_in     = 8'd3;
        for (int i = 0; i < 10; i++) begin
            check_val("t5_out_valid", out_valid, 1);
            check_val("t5_gcd_stable", gcd_out, 12);
            check_val("t5_in_ready", in_ready, 0);
            step();
        end
        pop_compare();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("t5_idle_in_ready", in_ready, 1);
        check_val("t5_idle_out_valid", out_valid, 0);
        exp_gcd_q.push_back(3);
        exp_iter_q.push_back(0);
        step();
        in_valid = 1'b0;
        check_val("t5_new_done", done_flag, 1);
        step();
        consume();

        // Reset mid-RUN
        offer(200, 3, 0, 0);
        check_val("t6_agtb", A_greater_B_flag, 1);
        run_cmd(1'b1, 1'b0);
        check_val("t6_iter1", iter_count, 1);
        rst       = 1'b1;
        cmd_sub_a = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        cmd_sub_a = 1'b0;
        out_ready = 1'b0;
        exp_gcd_q.delete();
        exp_iter_q.delete();
        check_val("t6_in_ready", in_ready, 1);
        check_val("t6_out_valid", out_valid, 0);
        check_val("t6_agtb0", A_greater_B_flag, 0);
        check_val("t6_done0", done_flag, 0);
        check_val("t6_iter0", iter_count, 0);
        check_val("t6_perr0", protocol_err, 0);

        // Commands while idle are ignored
        run_cmd(1'b1, 1'b1);
        check_val("t7_idle_perr", protocol_err, 0);
        check_val("t7_idle_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
